// File: rtl/key_evt_pkg.sv
// Shared event codes and FSM state encoding for the key event controller.
package key_evt_pkg;

  localparam logic [1:0] EV_SHORT  = 2'd0;
  localparam logic [1:0] EV_LONG   = 2'd1;
  localparam logic [1:0] EV_REPEAT = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESSED = 2'd1,
    S_HELD    = 2'd2
  } state_t;

endpackage

// File: rtl/key_hold_timer.sv
// Hold timer for the owned key: counts while enabled, clear has priority, saturates at all-ones.
module key_hold_timer #(
  parameter int              CNT_W      = 25,
  parameter logic [CNT_W-1:0] LONG_CNT   = 25'd25_000_000,
  parameter logic [CNT_W-1:0] REPEAT_CNT = 25'd10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic long_hit,
  output logic rep_hit
);

  localparam logic [CNT_W-1:0] LONG_TC = LONG_CNT - 1'b1;
  localparam logic [CNT_W-1:0] REP_TC  = REPEAT_CNT - 1'b1;

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign long_hit = (cnt_q == LONG_TC);
  assign rep_hit  = (cnt_q == REP_TC);

endmodule

// File: rtl/key_event_ctrl.sv
// Key arbiter/classifier: owns one debounced key at a time and emits SHORT/LONG/REPEAT events.
// Build option: define KEY_REPEAT_EN to emit REPEAT events while a long press is held.
//
// state     | meaning
// S_IDLE    | no key owned, waiting for a press edge
// S_PRESSED | key owned, timing towards long press
// S_HELD    | long press emitted, waiting for release (repeating if enabled)
module key_event_ctrl
  import key_evt_pkg::*;
#(
  parameter int               N_KEYS     = 4,
  parameter int               KEY_W      = 2,
  parameter int               CNT_W      = 25,
  parameter logic [CNT_W-1:0] LONG_CNT   = 25'd25_000_000,
  parameter logic [CNT_W-1:0] REPEAT_CNT = 25'd10_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_n,
  output logic              ev_valid,
  output logic [KEY_W-1:0]  ev_key,
  output logic [1:0]        ev_type,
  input  logic              ev_ready,
  output logic              ev_drop,
  output logic              busy
);

`ifdef KEY_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  state_t            state_q, state_d;
  logic [KEY_W-1:0]  own_q, own_d;
  logic [N_KEYS-1:0] key_d;
  logic [N_KEYS-1:0] press_edge;
  logic [KEY_W-1:0]  sel_key;
  logic              own_rel;
  logic              emit;
  logic [1:0]        emit_type;
  logic              tim_clr, tim_en;
  logic              long_hit, rep_hit;

  assign press_edge = key_d & ~key_n;
  assign own_rel    = key_n[own_q];
  assign busy       = (state_q != S_IDLE);

  // Descending scan so the lowest-index edge wins.
  always_comb begin
    sel_key = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (press_edge[i]) sel_key = i[KEY_W-1:0];
    end
  end

  key_hold_timer #(
    .CNT_W      (CNT_W),
    .LONG_CNT   (LONG_CNT),
    .REPEAT_CNT (REPEAT_CNT)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (tim_clr),
    .en       (tim_en),
    .long_hit (long_hit),
    .rep_hit  (rep_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      own_q   <= '0;
      key_d   <= '1;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      key_d   <= key_n;
    end
  end

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    case (state_q)
      S_IDLE: begin
        if (|press_edge) begin
          own_d   = sel_key;
          state_d = S_PRESSED;
        end
      end
      S_PRESSED: begin
        if (own_rel)       state_d = S_IDLE;
        else if (long_hit) state_d = S_HELD;
      end
      S_HELD: begin
        if (own_rel) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Release is checked ahead of the terminal counts.
  always_comb begin
    emit      = 1'b0;
    emit_type = EV_SHORT;
    tim_clr   = 1'b0;
    tim_en    = 1'b0;
    case (state_q)
      S_IDLE: tim_clr = 1'b1;
      S_PRESSED: begin
        if (own_rel) begin
          emit      = 1'b1;
          emit_type = EV_SHORT;
        end else if (long_hit) begin
          emit      = 1'b1;
          emit_type = EV_LONG;
          tim_clr   = 1'b1;
        end else begin
          tim_en = 1'b1;
        end
      end
      S_HELD: begin
        if (!own_rel && REP_EN) begin
          if (rep_hit) begin
            emit      = 1'b1;
            emit_type = EV_REPEAT;
            tim_clr   = 1'b1;
          end else begin
            tim_en = 1'b1;
          end
        end
      end
      default: tim_clr = 1'b1;
    endcase
  end

  // A pending, unaccepted event is never overwritten; the newcomer is reported as dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_valid <= 1'b0;
      ev_key   <= '0;
      ev_type  <= EV_SHORT;
      ev_drop  <= 1'b0;
    end else begin
      ev_drop <= 1'b0;
      if (emit) begin
        if (!ev_valid || ev_ready) begin
          ev_valid <= 1'b1;
          ev_key   <= own_q;
          ev_type  <= emit_type;
        end else begin
          ev_drop <= 1'b1;
        end
      end else if (ev_valid && ev_ready) begin
        ev_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Scoreboard bench for key_event_ctrl: directed scenarios plus randomized multi-key presses.
module tb_key_event_ctrl;

  localparam int N_KEYS = 4;
  localparam int KEY_W  = 2;
  localparam int CNT_W  = 25;
  localparam int LONG   = 100;
  localparam int REP    = 20;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N_KEYS-1:0] key_n;
  logic              ev_valid;
  logic [KEY_W-1:0]  ev_key;
  logic [1:0]        ev_type;
  logic              ev_ready;
  logic              ev_drop;
  logic              busy;

  key_event_ctrl #(
    .N_KEYS     (N_KEYS),
    .KEY_W      (KEY_W),
    .CNT_W      (CNT_W),
    .LONG_CNT   (25'd100),
    .REPEAT_CNT (25'd20)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_n    (key_n),
    .ev_valid (ev_valid),
    .ev_key   (ev_key),
    .ev_type  (ev_type),
    .ev_ready (ev_ready),
    .ev_drop  (ev_drop),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int key;
    int typ;
    int t;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   failed = 0;
  int   cyc = 0;
  int   drop_cnt = 0;
  int   valid_hi_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: a press held for h sampled cycles starting at t0 yields these events.
  task automatic expect_press(input int k, input int h, input int t0);
    if (h <= LONG) begin
      exp_q.push_back('{k, 0, t0 + h});
    end else begin
      exp_q.push_back('{k, 1, t0 + LONG});
`ifdef KEY_REPEAT_EN
      for (int r = 1; LONG + REP * r < h; r++) exp_q.push_back('{k, 2, t0 + LONG + REP * r});
`endif
    end
  endtask

  task automatic press(input int k, input int h, input bit push, input int gap);
    key_n[k] = 1'b0;
    if (push) expect_press(k, h, cyc + 1);
    repeat (h) tick();
    key_n[k] = 1'b1;
    repeat (gap) tick();
  endtask

  // Monitor: pops the scoreboard on every accepted event.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ev_drop) drop_cnt++;
      if (ev_valid) valid_hi_cnt++;
      if (ev_valid && ev_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL unexpected_event actual key=%0d type=%0d expected none (cycle %0d)",
                   ev_key, ev_type, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("ev_key", int'(ev_key), e.key);
          check("ev_type", int'(ev_type), e.typ);
          if (e.t >= 0) check("ev_time", cyc, e.t);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p[N_KEYS];
    int r[N_KEYS];
    int o, h, len, t0, d0, v0;

    rst_n    = 1'b0;
    key_n    = '1;
    ev_ready = 1'b1;
    repeat (3) tick();
    check("rst_ev_valid", int'(ev_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ev_drop", int'(ev_drop), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Short press on key 2.
    v0 = valid_hi_cnt;
    key_n[2] = 1'b0;
    expect_press(2, 30, cyc + 1);
    repeat (10) tick();
    check("t1_busy_held", int'(busy), 1);
    repeat (20) tick();
    key_n[2] = 1'b1;
    repeat (5) tick();
    check("t1_busy_after", int'(busy), 0);
    check("t1_valid_cycles", valid_hi_cnt - v0, 1);

    // Long press with repeats on key 1; nothing on release.
    press(1, 145, 1'b1, 8);
    check("t2_busy_after", int'(busy), 0);

    // Simultaneous keys 3 and 0: key 0 owned, key 3 silent until re-pressed.
    key_n[3] = 1'b0;
    key_n[0] = 1'b0;
    expect_press(0, 20, cyc + 1);
    repeat (20) tick();
    key_n[0] = 1'b1;
    repeat (30) tick();
    check("t4_idle_key3_low", int'(busy), 0);
    key_n[3] = 1'b1;
    repeat (3) tick();
    press(3, 10, 1'b1, 5);

    // Back-pressure: second event dropped, first held.
    ev_ready = 1'b0;
    press(1, 10, 1'b0, 5);
    exp_q.push_back('{1, 0, -1});
    check("t5_valid_pending", int'(ev_valid), 1);
    d0 = drop_cnt;
    press(1, 10, 1'b0, 5);
    check("t5_drop_pulses", drop_cnt - d0, 1);
    check("t5_hold_valid", int'(ev_valid), 1);
    check("t5_hold_key", int'(ev_key), 1);
    check("t5_hold_type", int'(ev_type), 0);
    ev_ready = 1'b1;
    repeat (2) tick();
    check("t5_valid_cleared", int'(ev_valid), 0);

    // Reset mid-press at hold cycle 50, key kept low through reset.
    key_n[2] = 1'b0;
    repeat (50) tick();
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", int'(ev_valid), 0);
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_drop", int'(ev_drop), 0);
    check("t6_rst_key", int'(ev_key), 0);
    check("t6_rst_type", int'(ev_type), 0);
    tick();
    tick();
    rst_n = 1'b1;
    expect_press(2, 130, cyc + 1);
    repeat (130) tick();
    key_n[2] = 1'b1;
    repeat (5) tick();

    // Randomized: owner plus other keys pressed while busy (all ignored).
    for (int it = 0; it < 25; it++) begin
      o = $urandom_range(0, N_KEYS - 1);
      h = $urandom_range(1, 160);
      len = h;
      for (int k = 0; k < N_KEYS; k++) begin
        p[k] = -1;
        r[k] = -1;
        if (k == o) begin
          p[k] = 0;
          r[k] = h;
        end else begin
          case ($urandom_range(0, 2))
            1: if (k > o) begin
                 p[k] = 0;
                 r[k] = $urandom_range(1, h + 15);
               end
            2: if (h >= 2) begin
                 p[k] = $urandom_range(1, h - 1);
                 r[k] = $urandom_range(p[k] + 1, h + 15);
               end
            default: ;
          endcase
          if (r[k] > len) len = r[k];
        end
      end
      t0 = cyc + 1;
      expect_press(o, h, t0);
      for (int j = 0; j < len; j++) begin
        for (int k = 0; k < N_KEYS; k++) key_n[k] = !(j >= p[k] && j < r[k]);
        tick();
      end
      key_n = '1;
      repeat (4) tick();
    end

    repeat (5) tick();
    check("all_events_seen", exp_q.size(), 0);
    check("total_drops", drop_cnt, 1);
    check("final_busy", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
